// File: rtl/pe_sram_pkg.sv
// Shared constants and the bank-select width helper for the banked PE scratch SRAM.
package pe_sram_pkg;
  localparam logic PORT_A         = 1'b0;
  localparam logic PORT_B         = 1'b1;
  localparam int   CONFLICT_CNT_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction
endpackage

// File: rtl/pe_sram_bank.sv
// One SRAM bank: single port, byte-strobe write, registered read data one cycle after enable.
// No reset on storage or read register; the top gates read data with its own valid.
module pe_sram_bank
  import pe_sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ROWS   = 256,
  parameter int ROW_W  = 8
) (
  input  logic                clk,
  input  logic                i_en,
  input  logic                i_we,
  input  logic [ROW_W-1:0]    i_row,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  output logic [DATA_W-1:0]   o_rdata
);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [ROWS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (i_wstrb[i]) r_mem[i_row][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_row];
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/pe_sram_banked.sv
// Two-port low-order-interleaved banked SRAM with round-robin same-bank arbitration.
// Reads return 1 cycle after acceptance; collision loser sees ready=0 and holds; responses never stall.
module pe_sram_banked
  import pe_sram_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int NUM_BANKS = 4,
  parameter int ADR_W     = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_req_valid,
  output logic                      a_req_ready,
  input  logic [ADR_W-1:0]          a_addr,
  input  logic                      a_we,
  input  logic [DATA_W-1:0]         a_wdata,
  input  logic [DATA_W/8-1:0]       a_wstrb,
  output logic                      a_rsp_valid,
  output logic [DATA_W-1:0]         a_rdata,
  input  logic                      b_req_valid,
  output logic                      b_req_ready,
  input  logic [ADR_W-1:0]          b_addr,
  input  logic                      b_we,
  input  logic [DATA_W-1:0]         b_wdata,
  input  logic [DATA_W/8-1:0]       b_wstrb,
  output logic                      b_rsp_valid,
  output logic [DATA_W-1:0]         b_rdata,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);
  localparam int BANK_W = clog2(NUM_BANKS);
  localparam int ROW_W  = ADR_W - BANK_W;
  localparam int ROWS   = DEPTH / NUM_BANKS;

  logic [BANK_W-1:0]         w_a_bank, w_b_bank;
  logic                      w_collide, w_a_acc, w_b_acc;
  logic                      r_prio;
  logic                      r_a_rsp_vld, r_b_rsp_vld;
  logic [BANK_W-1:0]         r_a_rsp_bank, r_b_rsp_bank;
  logic [CONFLICT_CNT_W-1:0] r_conflict_cnt;
  logic [DATA_W-1:0]         w_bank_rdata [NUM_BANKS];

  assign w_a_bank  = a_addr[BANK_W-1:0];
  assign w_b_bank  = b_addr[BANK_W-1:0];
  assign w_collide = a_req_valid & b_req_valid & (w_a_bank == w_b_bank);

  assign a_req_ready = rst_n & (~w_collide | (r_prio == PORT_A));
  assign b_req_ready = rst_n & (~w_collide | (r_prio == PORT_B));
  assign w_a_acc     = a_req_valid & a_req_ready;
  assign w_b_acc     = b_req_valid & b_req_ready;

  // Accepted requests always target distinct banks, so at most one select is active per bank.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic w_a_sel, w_b_sel;
    assign w_a_sel = w_a_acc & (w_a_bank == BANK_W'(g));
    assign w_b_sel = w_b_acc & (w_b_bank == BANK_W'(g));

    pe_sram_bank #(
      .DATA_W (DATA_W),
      .ROWS   (ROWS),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk     (clk),
      .i_en    (w_a_sel | w_b_sel),
      .i_we    (w_a_sel ? a_we : b_we),
      .i_row   (w_a_sel ? a_addr[ADR_W-1:BANK_W] : b_addr[ADR_W-1:BANK_W]),
      .i_wdata (w_a_sel ? a_wdata : b_wdata),
      .i_wstrb (w_a_sel ? a_wstrb : b_wstrb),
      .o_rdata (w_bank_rdata[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio         <= PORT_A;
      r_a_rsp_vld    <= 1'b0;
      r_b_rsp_vld    <= 1'b0;
      r_a_rsp_bank   <= '0;
      r_b_rsp_bank   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_a_rsp_vld  <= w_a_acc & ~a_we;
      r_b_rsp_vld  <= w_b_acc & ~b_we;
      r_a_rsp_bank <= w_a_bank;
      r_b_rsp_bank <= w_b_bank;
      if (w_collide) begin
        r_prio <= ~r_prio;
        if (r_conflict_cnt != '1) r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
    end
  end

  assign a_rsp_valid  = r_a_rsp_vld;
  assign b_rsp_valid  = r_b_rsp_vld;
  assign a_rdata      = r_a_rsp_vld ? w_bank_rdata[r_a_rsp_bank] : '0;
  assign b_rdata      = r_b_rsp_vld ? w_bank_rdata[r_b_rsp_bank] : '0;
  assign conflict_cnt = r_conflict_cnt;
endmodule

// File: doc/pe_sram_banked.md
# pe_sram_banked

Two-port, multi-bank, byte-writable SRAM for the PE tile; the parametrised successor of the single-port PE scratch SRAM. Two independent requesters (A: PE datapath, B: DMA/load-store) issue valid/ready requests; words are low-order interleaved across `NUM_BANKS` banks so requests to different banks proceed in parallel, and same-bank collisions are resolved by a round-robin arbiter. Reads return on a registered response one cycle after acceptance; a saturating counter reports bank conflicts.

## Interface
- `DATA_W`, 32, data width in bits; multiple of 8
- `DEPTH`, 1024, total words; power of two, multiple of `NUM_BANKS`
- `NUM_BANKS`, 4, bank count; power of two, ≥2
- `ADR_W`, 10, word address width; equals log2(`DEPTH`)
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `a_req_valid` / `b_req_valid`  in  1  request present
- `a_req_ready` / `b_req_ready`  out  1  request accepted this cycle when valid&ready
- `a_addr` / `b_addr`  in  `ADR_W`  word address
- `a_we` / `b_we`  in  1  1 = write, 0 = read
- `a_wdata` / `b_wdata`  in  `DATA_W`  write data
- `a_wstrb` / `b_wstrb`  in  `DATA_W/8`  byte enables for writes
- `a_rsp_valid` / `b_rsp_valid`  out  1  read data valid (one-cycle pulse per accepted read)
- `a_rdata` / `b_rdata`  out  `DATA_W`  read data; 0 when rsp_valid is 0
- `conflict_cnt`  out  16  saturating count of cycles with a same-bank collision

## Operation
- Bank = `addr[log2(NUM_BANKS)-1:0]`; row = `addr[ADR_W-1:log2(NUM_BANKS)]`.
- No collision (one valid, or both valid to different banks): every valid request is ready in the same cycle.
- Collision (both valid, same bank, any mix of read/write, including same address): only the port holding priority is ready; the other sees ready=0 and must hold its request stable.
- Priority register `prio` (0=A, 1=B): reset to A; after each collision it toggles to the loser. Unchanged in non-collision cycles.
- Write: bytes with `wstrb[i]=1` are updated at the accepting edge; others are retained. `wstrb=0` is a legal no-op write. Writes produce no response.
- Read: returns the row contents before any same-edge write; response cannot be backpressured.
- Memory contents are not cleared by reset; reads of unwritten rows return X in simulation.
- `conflict_cnt` increments once per collision cycle; it holds at 0xFFFF.

## Timing
- `req_ready` is combinational from both valids, both bank indices and `prio`; forced to 0 while `rst_n`=0.
- Read latency: fixed 1 cycle; request accepted at edge N, so `rsp_valid`=1 and `rdata` are valid in the cycle after edge N.
- Throughput: one request per port per cycle when banks differ; a collided pair completes in 2 cycles.
- Write followed by read to the same address on any port in the next cycle returns the new data.
- Reset asserted: `a/b_req_ready`=0, `a/b_rsp_valid`=0, `a/b_rdata`=0, `conflict_cnt`=0, `prio`=A, immediately (asynchronous). An in-flight read's response is dropped; writes at the asserting edge are not guaranteed.

## Structure
- Package `pe_sram_pkg`: bank-select width function (`clog2`), port ID constants (`PORT_A=0`, `PORT_B=1`), `CONFLICT_CNT_W=16`.
- Sub-module `pe_sram_bank`: one bank of `DEPTH/NUM_BANKS` rows, byte-strobe write, registered read data, single port; instantiated `NUM_BANKS` times via generate.
- Top level holds arbitration, per-bank mux of the granted port, read-return routing (registered bank index and port per read), and the counter.

## Test plan
- Reset then A writes 0xDEADBEEF to addr 5, strobe 0xF; A reads addr 5 -> `a_rsp_valid` one cycle after acceptance, `a_rdata`=0xDEADBEEF.
- A writes 0x11223344 to addr 8, then strobe 0x2 with 0xAABBCCDD -> read returns 0x1122CC44.
- A reads addr 0 and B reads addr 1 in the same cycle -> both ready, both responses next cycle, `conflict_cnt`=0.
- A and B both read addr 4 and 8 (bank 0) held for 2 cycles -> cycle 1 only A ready, cycle 2 B ready; `conflict_cnt`=1; next collision grants B first.
- A write 0x55 to addr 12 collides with B read of addr 12 with prio=A -> B's read, accepted next cycle, returns 0x55.
- Assert `rst_n` the cycle after a read is accepted -> `rsp_valid` stays 0, all outputs 0; force 0x10000 collisions -> `conflict_cnt` saturates at 0xFFFF.
